// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access path: size codes,
// response error codes, controller state encoding and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // The reserved size code is reported as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(size_e size, logic [1:0] offset);
        logic result;
        case (size)
            SZ_BYTE: result = 1'b0;
            SZ_HALF: result = offset[0];
            SZ_WORD: result = (offset != 2'b00);
            default: result = 1'b1;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] byte_enables(size_e size, logic [1:0] offset);
        logic [3:0] result;
        case (size)
            SZ_BYTE: result = 4'b0001 << offset;
            SZ_HALF: result = offset[1] ? 4'b1100 : 4'b0011;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] lane_replicate(size_e size, logic [31:0] wdata);
        logic [31:0] result;
        case (size)
            SZ_BYTE: result = {4{wdata[7:0]}};
            SZ_HALF: result = {2{wdata[15:0]}};
            default: result = wdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request, data-memory bus and response signals of the MEM-stage
// access unit; master is the access unit, slave is the pipeline/memory side.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        input  mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        output mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/half lane from a memory word and sign- or
// zero-extends it; words pass through unchanged.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        byte_lane = rdata_i[8*offset_i +: 8];
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: request -> req/ack bus cycle -> extended response.
// Define MEM_TRACE_EN to print a trace line for every successful store.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.master bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    err_e        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        we_q;
    size_e       size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic [31:0] load_data;

    assign accept = (state_q == IDLE) && bus.req_valid;

    load_align u_load_align (
        .rdata_i    (bus.mem_rdata),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Request payload is captured once at accept and held stable for the whole bus cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            we_q       <= bus.req_we;
            size_q     <= size_e'(bus.req_size);
            unsigned_q <= bus.req_unsigned;
            addr_q     <= bus.req_addr;
            be_q       <= byte_enables(size_e'(bus.req_size), bus.req_addr[1:0]);
            wdata_q    <= lane_replicate(size_e'(bus.req_size), bus.req_wdata);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (is_misaligned(size_e'(bus.req_size), bus.req_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus.mem_ack) begin
                    err_d   = ERR_OK;
                    rdata_d = we_q ? '0 : load_data;
                    state_d = RESP;
                end else if (cnt_d == TIMEOUT_CNT) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_req   = (state_q == ACCESS);
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_be    = be_q;
        bus.mem_wdata = wdata_q;
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.rsp_err   = (state_q == RESP) ? err_q : ERR_OK;
        bus.busy      = (state_q != IDLE) || bus.req_valid;
    end

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (accept) begin
            pc_q <= bus.req_pc;
        end
    end

    always @(posedge clk) begin
        if (!reset && state_q == ACCESS && bus.mem_ack && we_q) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, addr_q,
                     wdata_q & {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}});
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against an arithmetic model of sizes, lanes and extension.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd3) ? 4 : (1 << size);
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || ((addr % nbytes(size)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int off, n;
        off = int'(addr % 4);
        n   = nbytes(size);
        be  = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        int n;
        n = nbytes(size);
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [63:0] v, mask;
        int n;
        n    = nbytes(size);
        v    = {32'd0, rdata} >> (8 * (addr % 4));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- transaction driver ----------------
    // ack_at: ACCESS cycle (1-based) in which mem_ack is raised; 0 means never.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_at);
        logic        mis;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        logic        acked;
        mis   = model_misaligned(size, addr);
        acked = 1'b0;

        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_pc       = $urandom;
        @(negedge clk);
        check("accept_ready", bus.req_ready, 1);
        check("accept_busy", bus.busy, 1);
        check("accept_no_req", bus.mem_req, 0);
        step();
        bus.req_valid = 1'b0;

        if (mis) begin
            exp_err = 2'b01;
            exp_rd  = '0;
        end else begin
            for (int k = 1; k <= TO; k++) begin
                bus.mem_ack   = (k == ack_at);
                bus.mem_rdata = (k == ack_at) ? rdata : $urandom;
                @(negedge clk);
                check("access_mem_req", bus.mem_req, 1);
                check("access_mem_we", bus.mem_we, we);
                check("access_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                check("access_mem_be", bus.mem_be, model_be(size, addr));
                if (we) check("access_mem_wdata", bus.mem_wdata, model_wdata(size, wdata));
                check("access_no_rsp", bus.rsp_valid, 0);
                check("access_busy", bus.busy, 1);
                step();
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            bus.mem_ack = 1'b0;
            if (acked) begin
                exp_err = 2'b00;
                exp_rd  = we ? 32'd0 : model_load(size, uns, addr, rdata);
            end else begin
                exp_err = 2'b10;
                exp_rd  = '0;
            end
        end

        @(negedge clk);
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_err", bus.rsp_err, exp_err);
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_no_mem_req", bus.mem_req, 0);
        check("rsp_not_ready", bus.req_ready, 0);
        step();
        @(negedge clk);
        check("post_rsp_pulse_end", bus.rsp_valid, 0);
        check("post_rsp_ready", bus.req_ready, 1);
        check("post_rsp_idle_busy", bus.busy, 0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_pc       = '0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_mem_be", bus.mem_be, 0);
        check("reset_busy", bus.busy, 0);
        reset = 1'b0;
        step();

        // Store byte to the top lane
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
        // Half loads, signed then unsigned
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        // Misaligned word load and reserved size
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 1);
        run_txn(1'b1, 2'b11, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'h0, 1);
        // Timeout with no ack, then ack on the last allowed cycle
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, TO);

        // Ack while idle is ignored
        bus.mem_ack = 1'b1;
        @(negedge clk);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_no_rsp", bus.rsp_valid, 0);
        check("idle_ack_ready", bus.req_ready, 1);
        step();

        // Reset mid-ACCESS drops mem_req without a response
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_3000;
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_req_before", bus.mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req_dropped", bus.mem_req, 0);
        check("rst_mid_ready", bus.req_ready, 1);
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", bus.rsp_valid, 0);
            check("rst_mid_ready_after", bus.req_ready, 1);
            step();
        end

        // Back-to-back: lb then sw presented continuously
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0000_0010;
        step();
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0014;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_00F0;
        @(negedge clk);
        check("b2b_lb_access", bus.mem_req, 1);
        check("b2b_lb_not_ready", bus.req_ready, 0);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("b2b_lb_rsp_valid", bus.rsp_valid, 1);
        check("b2b_lb_rdata", bus.rsp_rdata, 32'hFFFF_FFF0);
        check("b2b_lb_rsp_not_ready", bus.req_ready, 0);
        step();
        @(negedge clk);
        check("b2b_sw_accept", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        check("b2b_sw_mem_req", bus.mem_req, 1);
        check("b2b_sw_be", bus.mem_be, 4'b1111);
        check("b2b_sw_addr", bus.mem_addr, 32'h0000_0014);
        check("b2b_sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("b2b_sw_rsp_valid", bus.rsp_valid, 1);
        check("b2b_sw_rsp_err", bus.rsp_err, 0);
        check("b2b_sw_rsp_rdata", bus.rsp_rdata, 0);
        step();

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'b01) r_addr[0] = 1'b0;
                if (r_size == 2'b10) r_addr[1:0] = 2'b00;
            end
            run_txn(r_we, r_size, r_uns, r_addr, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
